uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART byte transmitter among `NUM_REQ` on-chip requesters. It sits between client logic and the UART TX serializer inside `uart_top`. It accepts one byte at a time through valid/ready handshakes and launches each byte with a one-cycle start pulse. It tracks the serializer's busy flag so that only one byte is ever in flight, and supports packet locking so a multi-byte message is never interleaved with another requester's bytes.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width.
- `TIMEOUT_CYC`, 1024: watchdog limit in cycles; used only when `UART_ARB_TIMEOUT_EN` is defined.

Ports:
- `sys_clk` in 1: system clock. The block has one clock only.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester byte valid.
- `req_data` in NUM_REQ*DATA_W: requester i occupies bits `[i*DATA_W +: DATA_W]`.
- `req_last` in NUM_REQ: marks the offered byte as the last byte of its packet.
- `req_ready` out NUM_REQ: one-hot accept strobe.
- `tx_data` out DATA_W: byte presented to the serializer.
- `tx_start` out 1: one-cycle launch pulse to the serializer.
- `tx_busy` in 1: serializer busy; high from shortly after `tx_start` until the stop bit completes.
- `grant_id` out clog2(NUM_REQ): index of the current or most recent grantee.
- `en` out 1: high whenever the state is not ARB (transmission in progress).
- `timeout_err` out 1: one-cycle pulse when the watchdog fires.

## Operation
- States: ARB, START, WAIT_BUSY, WAIT_DONE.
- ARB, selection:
  - If locked, the candidate is `grant_id` only.
  - Otherwise, scan round-robin starting at `grant_id+1` (mod NUM_REQ) and pick the first asserted `req_valid`.
- ARB, accept:
  - If a candidate exists, `req_ready[cand]` is driven combinationally in the same cycle.
  - On that edge, register `tx_data`, `grant_id` and the lock flag (`lock <= ~req_last[cand]`), then go to START.
- START: `tx_start`=1 for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY: stay until `tx_busy`=1, then go to WAIT_DONE.
- WAIT_DONE: stay until `tx_busy`=0, then go to ARB.
- `req_ready` is 0 in every state except ARB.
- Requesters hold `req_valid`, `req_data` and `req_last` stable until accepted. The arbiter never drops an offered byte.
- Lock:
  - While locked, valid bytes from other requesters are ignored.
  - If the locked requester is not valid, ARB waits; it does not fall back to round-robin.
  - The lock is released when a byte with `req_last`=1 is accepted.
- Fairness: after an unlocked grant to i, requester i has the lowest priority in the next scan.

## Timing
- Reset values: state ARB, `tx_data`=0, `tx_start`=0, `grant_id`=NUM_REQ-1 (so requester 0 wins first), lock=0, `en`=0, `timeout_err`=0, `req_ready`=0.
- Reset mid-transmission returns to ARB immediately. A pending `tx_start` is suppressed.
- Latency: the cycle `req_valid` is seen in ARB gives `req_ready`; `tx_start` follows one cycle later.
- Minimum spacing between two accepts is 4 cycles (ARB, START, WAIT_BUSY ≥1, WAIT_DONE ≥1) plus the serializer busy time.
- `tx_busy` already high in START is ignored. Only the WAIT_BUSY sample counts.
- `tx_data` holds its value until the next accept.
- `grant_id` holds its value while idle.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- When defined:
  - A counter clears on entry to WAIT_BUSY and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches `TIMEOUT_CYC`, `timeout_err` pulses for one cycle, lock clears and the state returns to ARB.
  - The round-robin pointer keeps the failed grantee.
- When undefined: no counter; WAIT_BUSY and WAIT_DONE wait indefinitely; `timeout_err` is tied 0.

## Test plan
- Single request, `req_valid[2]`=1, `req_data`=0xA5, `req_last`=1; serializer model holds busy for 100 cycles. Expect `req_ready[2]` the same cycle, `tx_start` one cycle later with `tx_data`=0xA5, `en` high until busy falls, `grant_id`=2.
- All four requesters valid with distinct bytes, all `req_last`=1. Expect launch order 0,1,2,3, then 0 again on re-request; each requester gets exactly one `req_ready` per byte.
- Requester 1 sends 0x11, 0x22, 0x33 with `req_last` on the third byte while requester 3 stays valid. Expect 0x11, 0x22, 0x33 launched back-to-back before requester 3's byte.
- Lock held, requester 1 deasserts `req_valid` for 50 cycles while requester 0 is valid. Expect no `req_ready[0]`; requester 1 resumes and is accepted next.
- Assert `sys_rst_n`=0 during WAIT_DONE. Expect state ARB, all outputs at their reset values, and the next grant goes to requester 0.
- With `UART_ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=16, keep `tx_busy` stuck at 0. Expect a `timeout_err` pulse 16 cycles after entering WAIT_BUSY, return to ARB, and lock cleared.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte serializer among NUM_REQ requesters, with packet locking.
// Optional watchdog on a stuck serializer is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        en,
    output logic                        timeout_err
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {
        ARB,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic            lock;
    logic [ID_W-1:0] cand;
    logic            cand_ok;

    // Locked: only the current grantee may proceed. Otherwise scan downward so the
    // requester closest after grant_id is assigned last and therefore wins.
    always_comb begin
        int idx;
        cand    = '0;
        cand_ok = 1'b0;
        idx     = 0;
        if (lock) begin
            if (req_valid[grant_id]) begin
                cand    = grant_id;
                cand_ok = 1'b1;
            end
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                idx = (int'(grant_id) + k) % NUM_REQ;
                if (req_valid[idx]) begin
                    cand    = ID_W'(idx);
                    cand_ok = 1'b1;
                end
            end
        end
    end

    // Accept strobe is combinational and held off while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (sys_rst_n && (state == ARB) && cand_ok) begin
            req_ready[cand] = 1'b1;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ARB;
            tx_data  <= '0;
            tx_start <= 1'b0;
            grant_id <= ID_W'(NUM_REQ - 1);
            lock     <= 1'b0;
            en       <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            case (state)
                ARB: begin
                    if (cand_ok) begin
                        tx_data  <= req_data[int'(cand)*DATA_W +: DATA_W];
                        grant_id <= cand;
                        lock     <= ~req_last[cand];
                        tx_start <= 1'b1;
                        en       <= 1'b1;
                        state    <= START;
                    end
                end
                // Busy seen during START belongs to the launch itself and is ignored.
                START: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        en    <= 1'b0;
                        state <= ARB;
                    end
                end
                default: begin
                    en    <= 1'b0;
                    state <= ARB;
                end
            endcase
`ifdef UART_ARB_TIMEOUT_EN
            // Watchdog overrides the FSM; grant_id keeps the failed grantee.
            timeout_err <= 1'b0;
            if (state == START) begin
                wd_cnt <= '0;
            end else if ((state == WAIT_BUSY) || (state == WAIT_DONE)) begin
                if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                    timeout_err <= 1'b1;
                    lock        <= 1'b0;
                    en          <= 1'b0;
                    state       <= ARB;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of grant vectors plus hand-written reset, lock-stall and stuck-serializer sequences.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 16;

    logic                       sys_clk;
    logic                       sys_rst_n;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ-1:0]         req_ready;
    logic [DATA_W-1:0]          tx_data;
    logic                       tx_start;
    logic                       tx_busy;
    logic [1:0]                 grant_id;
    logic                       en;
    logic                       timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .en         (en),
        .timeout_err(timeout_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        int          exp_id;
        logic [7:0]  exp_data;
        int          busy;
    } vec_t;

    vec_t vecs[14];
    int   tests;
    int   fails;
    int   busy_len;
    int   busy_left;
    bit   stuck;

    // Serializer model: busy rises on the launch pulse and lasts busy_len cycles.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            busy_left = 0;
            tx_busy   = 1'b0;
        end else begin
            if (tx_start && !stuck) begin
                busy_left = busy_len;
            end else if (busy_left > 0) begin
                busy_left = busy_left - 1;
            end
            tx_busy = (busy_left > 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge sys_clk);
        busy_len  = v.busy;
        req_valid = v.valid;
        req_data  = v.data;
        req_last  = v.last;
    endtask

    // Offer one vector, expect an immediate grant, then follow the launch to completion.
    task automatic runVec(input vec_t v, input string tag);
        int waited;
        int cycles;
        applyStimulus(v);
        waited = 0;
        #1;
        while (req_ready == '0 && waited < 200) begin
            @(negedge sys_clk);
            #1;
            waited++;
        end
        checkOutput({tag, " latency"}, waited, 0);
        checkOutput({tag, " req_ready"}, {28'd0, req_ready}, 32'd1 << v.exp_id);
        @(posedge sys_clk);
        #1;
        req_valid[v.exp_id] = 1'b0;
        checkOutput({tag, " tx_start"}, {31'd0, tx_start}, 32'd1);
        checkOutput({tag, " tx_data"}, {24'd0, tx_data}, {24'd0, v.exp_data});
        checkOutput({tag, " grant_id"}, {30'd0, grant_id}, v.exp_id);
        checkOutput({tag, " ready_low"}, {28'd0, req_ready}, 32'd0);
        @(posedge sys_clk);
        #1;
        checkOutput({tag, " start_width"}, {31'd0, tx_start}, 32'd0);
        cycles = 1;
        while (en && cycles < 500) begin
            cycles++;
            @(posedge sys_clk);
            #1;
        end
        checkOutput({tag, " en_cycles"}, cycles, v.busy + 1);
        checkOutput({tag, " timeout_err"}, {31'd0, timeout_err}, 32'd0);
    endtask

    initial begin
        int   waited;
        int   n;
        bit   seen;
        vec_t hv;

        tests     = 0;
        fails     = 0;
        busy_len  = 3;
        stuck     = 1'b0;
        tx_busy   = 1'b0;
        busy_left = 0;
        sys_rst_n = 1'b0;
        req_valid = 4'b1111;
        req_data  = '0;
        req_last  = '0;

        vecs[0]  = '{4'b1111, 32'h43322110, 4'b1111, 0, 8'h10, 3};
        vecs[1]  = '{4'b1110, 32'h43322110, 4'b1111, 1, 8'h21, 3};
        vecs[2]  = '{4'b1100, 32'h43322110, 4'b1111, 2, 8'h32, 3};
        vecs[3]  = '{4'b1000, 32'h43322110, 4'b1111, 3, 8'h43, 3};
        vecs[4]  = '{4'b1111, 32'h47362514, 4'b1111, 0, 8'h14, 3};
        vecs[5]  = '{4'b1110, 32'h47362514, 4'b1111, 1, 8'h25, 3};
        vecs[6]  = '{4'b1100, 32'h47362514, 4'b1111, 2, 8'h36, 3};
        vecs[7]  = '{4'b1000, 32'h47362514, 4'b1111, 3, 8'h47, 3};
        vecs[8]  = '{4'b0100, 32'h00A50000, 4'b1111, 2, 8'hA5, 100};
        vecs[9]  = '{4'b0001, 32'h00000055, 4'b1111, 0, 8'h55, 2};
        vecs[10] = '{4'b1010, 32'h99001100, 4'b1000, 1, 8'h11, 4};
        vecs[11] = '{4'b1010, 32'h99002200, 4'b1000, 1, 8'h22, 4};
        vecs[12] = '{4'b1010, 32'h99003300, 4'b1010, 1, 8'h33, 4};
        vecs[13] = '{4'b1000, 32'h99000000, 4'b1000, 3, 8'h99, 4};

        // Reset values, with every requester offering during reset
        repeat (3) @(negedge sys_clk);
        #1;
        checkOutput("reset req_ready", {28'd0, req_ready}, 32'd0);
        checkOutput("reset tx_start", {31'd0, tx_start}, 32'd0);
        checkOutput("reset tx_data", {24'd0, tx_data}, 32'd0);
        checkOutput("reset grant_id", {30'd0, grant_id}, 32'd3);
        checkOutput("reset en", {31'd0, en}, 32'd0);
        checkOutput("reset timeout_err", {31'd0, timeout_err}, 32'd0);
        req_valid = '0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            runVec(vecs[i], $sformatf("vec%0d", i));
        end

        // Locked requester 1 goes idle; requester 0 must be held off
        runVec('{4'b0010, 32'h00001100, 4'b0000, 1, 8'h11, 3}, "lock_first");
        @(negedge sys_clk);
        req_valid = 4'b0001;
        req_data  = 32'h00000077;
        req_last  = 4'b0001;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (req_ready != '0) seen = 1'b1;
            @(negedge sys_clk);
        end
        checkOutput("lock_stall no_ready", {31'd0, seen}, 32'd0);
        runVec('{4'b0011, 32'h00002277, 4'b0011, 1, 8'h22, 3}, "lock_resume");
        runVec('{4'b0001, 32'h00000077, 4'b0001, 0, 8'h77, 3}, "lock_after");

        // Reset during WAIT_DONE
        hv = '{4'b0100, 32'h00C30000, 4'b0100, 2, 8'hC3, 100};
        applyStimulus(hv);
        waited = 0;
        #1;
        while (req_ready == '0 && waited < 20) begin
            @(negedge sys_clk);
            #1;
            waited++;
        end
        checkOutput("rst_mid req_ready", {28'd0, req_ready}, 32'h4);
        @(posedge sys_clk);
        #1;
        req_valid = '0;
        repeat (10) @(posedge sys_clk);
        #1;
        checkOutput("rst_mid en_before", {31'd0, en}, 32'd1);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        checkOutput("rst_mid req_ready", {28'd0, req_ready}, 32'd0);
        checkOutput("rst_mid tx_start", {31'd0, tx_start}, 32'd0);
        checkOutput("rst_mid tx_data", {24'd0, tx_data}, 32'd0);
        checkOutput("rst_mid grant_id", {30'd0, grant_id}, 32'd3);
        checkOutput("rst_mid en", {31'd0, en}, 32'd0);
        req_valid = '0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        runVec('{4'b0101, 32'h003C005A, 4'b0101, 0, 8'h5A, 3}, "rst_after");

        // Serializer never raises busy
        @(negedge sys_clk);
        stuck     = 1'b1;
        req_valid = 4'b0010;
        req_data  = 32'h00006600;
        req_last  = 4'b0000;
        waited = 0;
        #1;
        while (req_ready == '0 && waited < 20) begin
            @(negedge sys_clk);
            #1;
            waited++;
        end
        checkOutput("stuck req_ready", {28'd0, req_ready}, 32'h2);
        @(posedge sys_clk);
        #1;
        req_valid = '0;
        checkOutput("stuck tx_start", {31'd0, tx_start}, 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        while (!timeout_err && n < 100) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        checkOutput("timeout delay", n, 17);
        checkOutput("timeout en", {31'd0, en}, 32'd0);
        @(posedge sys_clk);
        #1;
        checkOutput("timeout pulse_width", {31'd0, timeout_err}, 32'd0);
        stuck = 1'b0;
        runVec('{4'b0001, 32'h00000088, 4'b0001, 0, 8'h88, 3}, "timeout_unlock");
`else
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge sys_clk);
            #1;
            if (timeout_err) seen = 1'b1;
        end
        checkOutput("stuck no_timeout", {31'd0, seen}, 32'd0);
        checkOutput("stuck en_held", {31'd0, en}, 32'd1);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        stuck     = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        runVec('{4'b0011, 32'h00002211, 4'b0011, 0, 8'h11, 3}, "stuck_recover");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
